window_gen_3x3: RTL and testbench



---
 rtl/cnn_pkg.sv | 25 ++
 rtl/line_buffer.sv | 23 ++
 rtl/window_gen_3x3.sv | 167 ++++++++++++++++
 tb/tb_window_gen_3x3.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN front-end blocks.
// Window taps are numbered row-major: W_TL (top-left) .. W_BR (bottom-right).
package cnn_pkg;
    localparam int DATA_W_DEF  = 8;
    localparam int IMG_W_DEF   = 418;
    localparam int IMG_H_DEF   = 418;
    localparam int COORD_W_DEF = 9;

    localparam int WIN_N = 9;
    localparam int W_TL  = 0;
    localparam int W_TC  = 1;
    localparam int W_TR  = 2;
    localparam int W_ML  = 3;
    localparam int W_MC  = 4;
    localparam int W_MR  = 5;
    localparam int W_BL  = 6;
    localparam int W_BC  = 7;
    localparam int W_BR  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } win_state_e;
endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage. Reads are combinational, so a write to the
// same address on the clock edge returns the old contents (read-before-write).
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 418,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end
endmodule

// File: rtl/window_gen_3x3.sv
// Raster-to-3x3-window converter: two line buffers feed the right column of a
// 3x3 tap register, which doubles as the output register of the window stream.
module window_gen_3x3
    import cnn_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic [DATA_W-1:0]       in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [WIN_N*DATA_W-1:0] win_o,
    output logic                    win_valid_o,
    input  logic                    win_ready_i,
    output logic [COORD_W-1:0]      win_row_o,
    output logic [COORD_W-1:0]      win_col_o,
    output logic                    win_last_o
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    win_state_e          state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [DATA_W-1:0]   tap_q [WIN_N];
    logic [DATA_W-1:0]   tap_d [WIN_N];
    logic                win_valid_q, win_valid_d;
    logic                win_last_q, win_last_d;
    logic                done_q, done_d;
    logic [COORD_W-1:0]  win_row_q, win_row_d;
    logic [COORD_W-1:0]  win_col_q, win_col_d;
    logic [DATA_W-1:0]   lb0_rd, lb1_rd;
    logic                accept, at_end, win_fire;

    // Handshake: a pixel moves when in_valid_i && in_ready_o at a rising edge;
    // a window moves when win_valid_o && win_ready_i. Outputs hold while stalled.
    assign in_ready_o = (state_q == RUN) && (!win_valid_q || win_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign at_end     = (row_q == ROW_MAX) && (col_q == COL_MAX);
    // Columns 0..1 still hold the previous row's pixels, so they never emit.
    assign win_fire   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
        .clk_i   (clk_i),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (in_data_i),
        .rdata_o (lb0_rd)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk_i   (clk_i),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        tap_d       = tap_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (accept && at_end) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (win_valid_q && win_ready_i && win_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            tap_d[W_TL] = tap_q[W_TC];
            tap_d[W_TC] = tap_q[W_TR];
            tap_d[W_ML] = tap_q[W_MC];
            tap_d[W_MC] = tap_q[W_MR];
            tap_d[W_BL] = tap_q[W_BC];
            tap_d[W_BC] = tap_q[W_BR];
            tap_d[W_TR] = lb1_rd;
            tap_d[W_MR] = lb0_rd;
            tap_d[W_BR] = in_data_i;
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // A new window takes priority over clearing on a handshake.
        if (win_fire) begin
            win_valid_d = 1'b1;
            win_last_d  = at_end;
            win_row_d   = COORD_W'(row_q - RW'(2));
            win_col_d   = COORD_W'(col_q - CW'(2));
        end else if (win_ready_i) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            done_q      <= 1'b0;
            for (int k = 0; k < WIN_N; k++) begin
                tap_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            done_q      <= done_d;
            tap_q       <= tap_d;
        end
    end

    for (genvar k = 0; k < WIN_N; k++) begin : g_win
        assign win_o[k*DATA_W +: DATA_W] = tap_q[k];
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign win_valid_o = win_valid_q;
    assign win_last_o  = win_last_q;
    assign win_row_o   = win_row_q;
    assign win_col_o   = win_col_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 5x4 image: table of frame scenarios, a
// window-list reference model, and hand-written reset sequences.
module tb_window_gen_3x3;
    localparam int DW    = 8;
    localparam int IW    = 5;
    localparam int IH    = 4;
    localparam int CWD   = 9;
    localparam int NPIX  = IW * IH;
    localparam int EXP_W = 9 * DW + 2 * CWD + 1;

    localparam int M_FULL  = 0;
    localparam int M_BP    = 1;
    localparam int M_BUB   = 2;
    localparam int M_START = 3;
    localparam int M_RND   = 4;

    localparam int F_PAT   = 0;
    localparam int F_NEG   = 1;
    localparam int F_RND   = 2;

    logic                clk_i = 1'b0;
    logic                rst_n = 1'b0;
    logic                start_i = 1'b0;
    logic                busy_o, done_o;
    logic [DW-1:0]       in_data_i = '0;
    logic                in_valid_i = 1'b0;
    logic                in_ready_o;
    logic [9*DW-1:0]     win_o;
    logic                win_valid_o;
    logic                win_ready_i = 1'b1;
    logic [CWD-1:0]      win_row_o, win_col_o;
    logic                win_last_o;

    window_gen_3x3 #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .COORD_W(CWD)) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .win_o       (win_o),
        .win_valid_o (win_valid_o),
        .win_ready_i (win_ready_i),
        .win_row_o   (win_row_o),
        .win_col_o   (win_col_o),
        .win_last_o  (win_last_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int               mode;
        int               fill;
        int               exp_windows;
        int               exp_dones;
        bit               chk_ends;
        logic [EXP_W-1:0] exp_first;
        logic [EXP_W-1:0] exp_last;
    } vec_t;

    logic [DW-1:0]    pix [NPIX];
    logic [EXP_W-1:0] exp_q [$];
    int               checks = 0;
    int               failures = 0;
    int               n_hs, n_done;
    logic [EXP_W-1:0] first_act, last_act;
    vec_t             tbl [8];

    task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fill_frame(input int kind);
        for (int i = 0; i < NPIX; i++) begin
            case (kind)
                F_PAT:   pix[i] = DW'(i);
                F_NEG:   pix[i] = 8'h80;
                default: pix[i] = DW'($urandom);
            endcase
        end
    endtask

    // Every unpadded stride-1 window in raster order, straight from the image.
    task automatic build_expected();
        logic [9*DW-1:0] w;
        exp_q.delete();
        for (int r0 = 0; r0 <= IH - 3; r0++) begin
            for (int c0 = 0; c0 <= IW - 3; c0++) begin
                for (int k = 0; k < 9; k++) begin
                    w[k*DW +: DW] = pix[(r0 + k / 3) * IW + c0 + k % 3];
                end
                exp_q.push_back({(r0 == IH - 3 && c0 == IW - 3), CWD'(r0), CWD'(c0), w});
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    function automatic logic [EXP_W-1:0] out_word();
        return {win_last_o, win_row_o, win_col_o, win_o};
    endfunction

    task automatic run_frame(input int mode, input int fill);
        int idx = 0;
        int stall = 0;
        int last_hs = -10;
        int done_cyc = -1;
        logic [EXP_W-1:0] held = '0;
        logic [EXP_W-1:0] act;
        n_hs = 0;
        n_done = 0;
        fill_frame(fill);
        build_expected();
        pulse_start();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            if (done_o) begin
                n_done++;
                check("done_timing", cyc, last_hs + 1);
                check("busy_at_done", busy_o, 1'b0);
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            case (mode)
                M_BP:    win_ready_i = !(win_valid_o && win_row_o == 0 && win_col_o == 1 && stall < 4);
                M_RND:   win_ready_i = ($urandom_range(0, 3) != 0);
                default: win_ready_i = 1'b1;
            endcase
            if (!win_ready_i && mode == M_BP) begin
                if (stall == 0) held = out_word();
                else check("stall_hold", out_word(), held);
                stall++;
            end
            case (mode)
                M_BUB:   in_valid_i = (idx < NPIX) && (cyc % 2 == 0);
                M_RND:   in_valid_i = (idx < NPIX) && ($urandom_range(0, 1) == 1);
                default: in_valid_i = (idx < NPIX);
            endcase
            in_data_i = (idx < NPIX) ? pix[idx] : '0;
            start_i = (mode == M_START && cyc == 7);
            #1;
            if (!win_ready_i && mode == M_BP) check("stall_in_ready", in_ready_o, 1'b0);
            if (win_valid_o && win_ready_i) begin
                act = out_word();
                if (exp_q.size() == 0) begin
                    check("extra_window", act, '0);
                end else begin
                    check($sformatf("window_%0d", n_hs), act, exp_q.pop_front());
                end
                if (n_hs == 0) first_act = act;
                last_act = act;
                n_hs++;
                last_hs = cyc;
            end
            if (in_valid_i && in_ready_o) idx++;
        end
        if (done_cyc < 0) check("frame_timeout", 1'b1, 1'b0);
        check("stall_seen", (mode == M_BP) ? (stall >= 4) : 1'b1, 1'b1);
        check("exp_queue_empty", exp_q.size(), 0);
        start_i = 1'b0;
        in_valid_i = 1'b0;
        win_ready_i = 1'b1;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {busy_o, done_o, in_ready_o, win_valid_o, win_last_o, win_row_o, win_col_o, win_o}, '0);
    endtask

    task automatic mid_frame_reset();
        int idx = 0;
        fill_frame(F_PAT);
        pulse_start();
        for (int c = 0; c < 100 && idx < 12; c++) begin
            @(negedge clk_i);
            win_ready_i = 1'b1;
            in_valid_i = 1'b1;
            in_data_i = pix[idx];
            #1;
            if (in_ready_o) idx++;
        end
        check("mid_pixels_taken", idx, 12);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset_outputs");
        @(negedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("mid_reset_held");
        rst_n = 1'b1;
    endtask

    initial begin
        logic [EXP_W-1:0] pat_first, pat_last, neg_first, neg_last;
        pat_first = {1'b0, 9'd0, 9'd0, 8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
        pat_last  = {1'b1, 9'd1, 9'd2, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7};
        neg_first = {1'b0, 9'd0, 9'd0, {9{8'h80}}};
        neg_last  = {1'b1, 9'd1, 9'd2, {9{8'h80}}};

        tbl[0] = '{M_FULL,  F_PAT, 6, 1, 1'b1, pat_first, pat_last};
        tbl[1] = '{M_BP,    F_PAT, 6, 1, 1'b1, pat_first, pat_last};
        tbl[2] = '{M_BUB,   F_PAT, 6, 1, 1'b1, pat_first, pat_last};
        tbl[3] = '{M_FULL,  F_NEG, 6, 1, 1'b1, neg_first, neg_last};
        tbl[4] = '{M_START, F_PAT, 6, 1, 1'b1, pat_first, pat_last};
        tbl[5] = '{M_RND,   F_RND, 6, 1, 1'b0, '0, '0};
        tbl[6] = '{M_RND,   F_RND, 6, 1, 1'b0, '0, '0};
        tbl[7] = '{M_BUB,   F_RND, 6, 1, 1'b0, '0, '0};

        repeat (2) @(negedge clk_i);
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk_i);
        check("idle_not_busy", {busy_o, in_ready_o}, 2'b00);

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].mode, tbl[i].fill);
            check($sformatf("v%0d_windows", i), n_hs, tbl[i].exp_windows);
            check($sformatf("v%0d_dones", i), n_done, tbl[i].exp_dones);
            if (tbl[i].chk_ends) begin
                check($sformatf("v%0d_first", i), first_act, tbl[i].exp_first);
                check($sformatf("v%0d_last", i), last_act, tbl[i].exp_last);
            end
        end

        mid_frame_reset();
        run_frame(M_FULL, F_PAT);
        check("post_reset_windows", n_hs, 6);
        check("post_reset_dones", n_done, 1);
        check("post_reset_first", first_act, pat_first);
        check("post_reset_last", last_act, pat_last);

        for (int i = 0; i < 4; i++) begin
            run_frame(M_RND, F_RND);
            check($sformatf("rnd%0d_windows", i), n_hs, 6);
            check($sformatf("rnd%0d_dones", i), n_done, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
